// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: one-hot grant held while the winner keeps requesting,
// rotating priority pointer advanced on release. Optional grant timeout via RR_ARB_TIMEOUT_EN.
module rr_arbiter8 #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [IDW:0] N_W = (IDW+1)'(N);

    if (N < 2 || N > 8 || IDW != $clog2(N) || MAX_HOLD < 2) begin : g_bad_params
        $error("rr_arbiter8: inconsistent parameters N/IDW/MAX_HOLD");
    end

    // (a + b) mod N, where a < N and b < N so one conditional subtract suffices
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input logic [IDW:0] b);
        logic [IDW:0] s;
        s = {1'b0, a} + b;
        if (s >= N_W) s = s - N_W;
        return s[IDW-1:0];
    endfunction

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           gnt_valid_q, gnt_valid_d;

    logic [IDW-1:0] rot_idx [N];
    logic [N-1:0]   rot_req;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] next_ptr;

    // rot_req[k] is the request of the requester k places after ptr
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign rot_idx[gi] = wrap_add(ptr_q, (IDW+1)'(gi));
        assign rot_req[gi] = req[rot_idx[gi]];
    end

    always_comb begin
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) win_idx = rot_idx[i];
        end
    end

    assign next_ptr = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic           timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
`ifdef RR_ARB_TIMEOUT_EN
        hcnt_d      = hcnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    gnt_id_d       = win_idx;
                    gnt_valid_d    = 1'b1;
                    state_d        = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                    hcnt_d         = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[gnt_id_q]) begin
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = next_ptr;
                    state_d     = IDLE;
`ifdef RR_ARB_TIMEOUT_EN
                end else if (hcnt_q == HCW'(MAX_HOLD - 1)) begin
                    // Revoke: the holder keeps requesting and competes again from IDLE
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = next_ptr;
                    state_d     = IDLE;
                    timeout_d   = 1'b1;
                end else begin
                    hcnt_d      = hcnt_q + HCW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            hcnt_q      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
`ifdef RR_ARB_TIMEOUT_EN
            hcnt_q      <= hcnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
`ifdef RR_ARB_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule
